// File: rtl/mc_pkg.sv
// Shared types and select codes for the multicycle sequencer.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } statetype;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_EXT  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

endpackage

// File: rtl/flopenr.sv
// Enabled register with asynchronous active-high reset.
module flopenr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mc_cond_eval.sv
// ARM condition-code check against the stored {N,Z,C,V} flags.
module mc_cond_eval (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v, ge;

  assign {n, z, c, v} = flags;
  assign ge = (n == v);

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~(c & ~z);
      4'b1010: cond_ex = ge;
      4'b1011: cond_ex = ~ge;
      4'b1100: cond_ex = ~z & ge;
      4'b1101: cond_ex = z | ~ge;
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle sequencer: Moore main FSM, ALU decode, condition check and write gating.
module mc_control_fsm
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  state_o
);

  // Instr carries IR[31:12], so IR bit k sits at Instr[k-12].
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       l_bit, s_bit;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign l_bit     = Instr[8];
  assign s_bit     = Instr[8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  statetype   state_q, state_d;
  logic       next_pc, branch, reg_w, mem_w, alu_op;
  logic [1:0] flag_w, flag_write;
  logic [1:0] flags_nz_q, flags_cv_q;
  logic       cond_ex, pcs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next state and Moore control values.
  always_comb begin
    state_d   = FETCH;
    next_pc   = 1'b0;
    branch    = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    alu_op    = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        next_pc   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        state_d   = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (cond_ex) begin
          case (op)
            2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
            2'b01:   state_d = MEMADR;
            2'b10:   state_d = BRANCH;
            default: state_d = FETCH;
          endcase
        end
      end
      MEMADR: begin
        ALUSrcB = SRCB_EXT;
        state_d = l_bit ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECUTER: begin
        ALUSrcB = SRCB_REG;
        alu_op  = 1'b1;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB = SRCB_EXT;
        alu_op  = 1'b1;
        state_d = ALUWB;
      end
      ALUWB: reg_w = 1'b1;
      BRANCH: begin
        ALUSrcB   = SRCB_EXT;
        ResultSrc = RES_ALURESULT;
        branch    = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // ALU operation and flag-write request; unknown commands leave flags alone.
  always_comb begin
    ALUControl = ALU_ADD;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (funct[4:1])
        4'b0100: begin ALUControl = ALU_ADD; flag_w = {s_bit, s_bit}; end
        4'b0010: begin ALUControl = ALU_SUB; flag_w = {s_bit, s_bit}; end
        4'b0000: begin ALUControl = ALU_AND; flag_w = {s_bit, 1'b0};  end
        4'b1100: begin ALUControl = ALU_ORR; flag_w = {s_bit, 1'b0};  end
        default: ;
      endcase
    end
  end

  mc_cond_eval u_cond_eval (
    .cond    (cond),
    .flags   ({flags_nz_q, flags_cv_q}),
    .cond_ex (cond_ex)
  );

  assign flag_write = flag_w & {2{cond_ex}};

  flopenr #(.WIDTH(2)) u_flags_nz (
    .clk   (clk),
    .reset (reset),
    .en    (flag_write[1]),
    .d     (ALUFlags[3:2]),
    .q     (flags_nz_q)
  );

  flopenr #(.WIDTH(2)) u_flags_cv (
    .clk   (clk),
    .reset (reset),
    .en    (flag_write[0]),
    .d     (ALUFlags[1:0]),
    .q     (flags_cv_q)
  );

  // A register write to R15 redirects the PC just like a taken branch.
  assign pcs      = branch | (reg_w & (rd == 4'hF));
  assign PCWrite  = next_pc | (pcs & cond_ex);
  assign RegWrite = reg_w & cond_ex;
  assign MemWrite = mem_w & cond_ex;
  assign ImmSrc   = op;
  assign RegSrc   = {(op == 2'b01) & ~l_bit, op == 2'b10};
  assign state_o  = 4'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Cycle-by-cycle scoreboard bench for the multicycle sequencer.
module tb_mc_control_fsm;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0]  state_o;

  mc_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upper 20 bits (IR[31:12]) of each instruction word.
  localparam logic [19:0] I_ADD   = 20'hE2801;  // ADD  R1,R0,#5
  localparam logic [19:0] I_LDR   = 20'hE5902;  // LDR  R2,[R0,#8]
  localparam logic [19:0] I_LDRPC = 20'hE590F;  // LDR  PC,[R0,#8]
  localparam logic [19:0] I_STR   = 20'hE5802;  // STR
  localparam logic [19:0] I_SUBS  = 20'hE0511;  // SUBS R1,R1,R1
  localparam logic [19:0] I_BEQ   = 20'h0A000;
  localparam logic [19:0] I_BCS   = 20'h2A000;
  localparam logic [19:0] I_BVS   = 20'h6A000;
  localparam logic [19:0] I_ANDS  = 20'hE2100;  // ANDS R0,R0,#0
  localparam logic [19:0] I_NV    = 20'hF2801;  // cond=1111

  // {state, PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,ALUSrcA, ResultSrc, ALUSrcB, ALUControl}
  localparam logic [15:0] E_FETCH    = {4'd0, 6'b110001, 2'b10, 2'b10, 2'b00};
  localparam logic [15:0] E_DECODE   = {4'd1, 6'b000001, 2'b10, 2'b10, 2'b00};
  localparam logic [15:0] E_MEMADR   = {4'd2, 6'b000000, 2'b00, 2'b01, 2'b00};
  localparam logic [15:0] E_MEMREAD  = {4'd3, 6'b000010, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] E_MEMWB    = {4'd4, 6'b001000, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] E_MEMWB_PC = {4'd4, 6'b101000, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] E_MEMWRITE = {4'd5, 6'b000110, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] E_EXR_SUB  = {4'd6, 6'b000000, 2'b00, 2'b00, 2'b01};
  localparam logic [15:0] E_EXI_ADD  = {4'd7, 6'b000000, 2'b00, 2'b01, 2'b00};
  localparam logic [15:0] E_EXI_AND  = {4'd7, 6'b000000, 2'b00, 2'b01, 2'b10};
  localparam logic [15:0] E_ALUWB    = {4'd8, 6'b001000, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] E_BRANCH   = {4'd9, 6'b100000, 2'b10, 2'b01, 2'b00};

  typedef struct packed {
    logic        rst;
    logic [19:0] instr;
    logic [3:0]  flags;
    logic [15:0] exp;
  } item_t;

  item_t       sb[$];
  item_t       it;
  int unsigned total;
  int unsigned passed;
  logic [15:0] obs;

  assign obs = {state_o, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                ResultSrc, ALUSrcB, ALUControl};

  function automatic logic [3:0] rf();
    return 4'($urandom);
  endfunction

  function automatic void push(input logic rst, input logic [19:0] instr,
                               input logic [3:0] fl, input logic [15:0] ex);
    item_t x;
    x.rst   = rst;
    x.instr = instr;
    x.flags = fl;
    x.exp   = ex;
    sb.push_back(x);
  endfunction

  // Apply one cycle of stimulus on the falling edge and let outputs settle.
  task automatic apply(input item_t x);
    @(negedge clk);
    reset    = x.rst;
    Instr    = x.instr;
    ALUFlags = x.flags;
    #1;
  endtask

  task automatic test_reset();
    push(1'b1, 20'h0, rf(), E_FETCH);
    push(1'b1, 20'h0, rf(), E_FETCH);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      total++;
      if (obs !== it.exp) $display("FAIL reset: got %h expected %h", obs, it.exp);
      else passed++;
    end
  endtask

  task automatic test_add_stream();
    for (int k = 0; k < 2; k++) begin
      push(1'b0, I_ADD, rf(), E_FETCH);
      push(1'b0, I_ADD, rf(), E_DECODE);
      push(1'b0, I_ADD, rf(), E_EXI_ADD);
      push(1'b0, I_ADD, rf(), E_ALUWB);
    end
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      total++;
      if (obs !== it.exp) $display("FAIL add_stream: got %h expected %h", obs, it.exp);
      else passed++;
    end
  endtask

  task automatic test_ldr();
    push(1'b0, I_LDR, rf(), E_FETCH);
    push(1'b0, I_LDR, rf(), E_DECODE);
    push(1'b0, I_LDR, rf(), E_MEMADR);
    push(1'b0, I_LDR, rf(), E_MEMREAD);
    push(1'b0, I_LDR, rf(), E_MEMWB);
    push(1'b0, I_LDRPC, rf(), E_FETCH);
    push(1'b0, I_LDRPC, rf(), E_DECODE);
    push(1'b0, I_LDRPC, rf(), E_MEMADR);
    push(1'b0, I_LDRPC, rf(), E_MEMREAD);
    push(1'b0, I_LDRPC, rf(), E_MEMWB_PC);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      total++;
      if (obs !== it.exp) $display("FAIL ldr: got %h expected %h", obs, it.exp);
      else passed++;
    end
  endtask

  task automatic test_str();
    push(1'b0, I_STR, rf(), E_FETCH);
    push(1'b0, I_STR, rf(), E_DECODE);
    push(1'b0, I_STR, rf(), E_MEMADR);
    push(1'b0, I_STR, rf(), E_MEMWRITE);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      total++;
      if (obs !== it.exp) $display("FAIL str: got %h expected %h", obs, it.exp);
      else passed++;
    end
    total++;
    if ({RegSrc, ImmSrc} !== 4'b1001)
      $display("FAIL str_regsrc_immsrc: got %b expected 1001", {RegSrc, ImmSrc});
    else passed++;
  endtask

  task automatic test_flags_branch();
    // SUBS producing zero, then BEQ taken.
    push(1'b0, I_SUBS, rf(),   E_FETCH);
    push(1'b0, I_SUBS, rf(),   E_DECODE);
    push(1'b0, I_SUBS, 4'b0100, E_EXR_SUB);
    push(1'b0, I_SUBS, rf(),   E_ALUWB);
    push(1'b0, I_BEQ,  rf(),   E_FETCH);
    push(1'b0, I_BEQ,  rf(),   E_DECODE);
    push(1'b0, I_BEQ,  rf(),   E_BRANCH);
    // SUBS producing non-zero, then BEQ falls through in two cycles.
    push(1'b0, I_SUBS, rf(),   E_FETCH);
    push(1'b0, I_SUBS, rf(),   E_DECODE);
    push(1'b0, I_SUBS, 4'b0000, E_EXR_SUB);
    push(1'b0, I_SUBS, rf(),   E_ALUWB);
    push(1'b0, I_BEQ,  rf(),   E_FETCH);
    push(1'b0, I_BEQ,  rf(),   E_DECODE);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      total++;
      if (obs !== it.exp) $display("FAIL flags_branch: got %h expected %h", obs, it.exp);
      else passed++;
    end
  endtask

  task automatic test_ands_cond();
    // Clear all flags, then ANDS with ALUFlags=1111 should leave NZCV=1100.
    push(1'b0, I_SUBS, rf(),   E_FETCH);
    push(1'b0, I_SUBS, rf(),   E_DECODE);
    push(1'b0, I_SUBS, 4'b0000, E_EXR_SUB);
    push(1'b0, I_SUBS, rf(),   E_ALUWB);
    push(1'b0, I_ANDS, rf(),   E_FETCH);
    push(1'b0, I_ANDS, rf(),   E_DECODE);
    push(1'b0, I_ANDS, 4'b1111, E_EXI_AND);
    push(1'b0, I_ANDS, rf(),   E_ALUWB);
    push(1'b0, I_BCS,  rf(),   E_FETCH);
    push(1'b0, I_BCS,  rf(),   E_DECODE);
    push(1'b0, I_BVS,  rf(),   E_FETCH);
    push(1'b0, I_BVS,  rf(),   E_DECODE);
    push(1'b0, I_BEQ,  rf(),   E_FETCH);
    push(1'b0, I_BEQ,  rf(),   E_DECODE);
    push(1'b0, I_BEQ,  rf(),   E_BRANCH);
    push(1'b0, I_NV,   rf(),   E_FETCH);
    push(1'b0, I_NV,   rf(),   E_DECODE);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      total++;
      if (obs !== it.exp) $display("FAIL ands_cond: got %h expected %h", obs, it.exp);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    // Z is set here; the post-reset BEQ must see cleared flags.
    push(1'b0, I_STR, rf(), E_FETCH);
    push(1'b0, I_STR, rf(), E_DECODE);
    push(1'b0, I_STR, rf(), E_MEMADR);
    push(1'b0, I_STR, rf(), E_MEMWRITE);
    push(1'b1, I_STR, rf(), E_FETCH);
    push(1'b0, I_BEQ, rf(), E_FETCH);
    push(1'b0, I_BEQ, rf(), E_DECODE);
    push(1'b0, I_ADD, rf(), E_FETCH);
    push(1'b0, I_ADD, rf(), E_DECODE);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      apply(it);
      total++;
      if (obs !== it.exp) $display("FAIL reset_mid: got %h expected %h", obs, it.exp);
      else passed++;
    end
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    reset    = 1'b1;
    Instr    = 20'h0;
    ALUFlags = 4'h0;
    test_reset();
    test_add_stream();
    test_ldr();
    test_str();
    test_flags_branch();
    test_ands_cond();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle sequencer for the ARMv4-subset core: a Moore main FSM plus ALU decode and condition logic that drives a shared-ALU, single-memory multicycle datapath. Each instruction takes 2–5 cycles, in place of the single-cycle decoder/condition path. It supports ADD/SUB/AND/ORR (register and imm8), LDR/STR (imm12), and B, all with condition codes.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- Instr  in  20  IR bits [31:12]; stable from DECODE until the next FETCH
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle
- PCWrite  out  1  load PC
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load IR
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  ALU input A select: 0=RegA, 1=PC
- ALUSrcB  out  2  ALU input B select: 00=RegB, 01=ExtImm, 10=const 4
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ImmSrc  out  2  equals Instr[27:26]
- RegSrc  out  2  [0]=(Op==10); [1]=(Op==01 & ~Instr[20])
- state_o  out  4  current state, for debug

## Operation
- Field names: Op=Instr[27:26], Funct=Instr[25:20], L=Instr[20], S=Instr[20], Rd=Instr[15:12], Cond=Instr[31:28].
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Codes 10–15 go to FETCH.
- Per-state outputs (any signal not listed is 0):
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE: if CondEx=0 →FETCH. Otherwise Op=01→MEMADR; Op=00 & ~Funct[5]→EXECUTER; Op=00 & Funct[5]→EXECUTEI; Op=10→BRANCH; Op=11→FETCH (NOP).
  - MEMADR: L→MEMREAD, else →MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER/EXECUTEI→ALUWB→FETCH.
  - BRANCH→FETCH.
- ALU decode when ALUOp=1, from Funct[4:1]:
  - 0100→00, 0010→01, 0000→10, 1100→11.
  - Any other value→00 with FlagW=00.
  - FlagW[1]=S; FlagW[0]=S & (ADD|SUB).
- When ALUOp=0: ALUControl=00 and FlagW=00.
- Condition evaluation:
  - Cond uses the stored Flags register, not ALUFlags. Standard ARM table for 0000–1110.
  - Cond=1110 gives CondEx=1; Cond=1111 gives CondEx=0.
- Write gating:
  - PCS = Branch | (RegW & Rd==1111).
  - PCWrite = NextPC | (PCS & CondEx).
  - RegWrite = RegW & CondEx; MemWrite = MemW & CondEx.
  - FlagWrite = FlagW & {2{CondEx}}.
- Flags register:
  - {N,Z} loads on FlagWrite[1]; {C,V} loads on FlagWrite[0].
  - Writes happen only at the edge that ends EXECUTER or EXECUTEI.

## Timing
- State register and Flags update on posedge clk. Reset is asynchronous: state=FETCH, Flags=0000.
- While reset is asserted, outputs are the FETCH Moore values (IRWrite=1, PCWrite=1). The datapath flops are held by their own reset.
- Outputs are Moore functions of state, plus combinational functions of Instr and Flags for ALUControl, ImmSrc, RegSrc and gating. There are no Mealy paths from ALUFlags.
- Cycles per instruction:
  - LDR 5, STR 4, DP 4, B 3.
  - Condition-failed instruction or Op=11: 2.
- A DP write to Rd=15 in ALUWB, or an LDR to Rd=15 in MEMWB, asserts PCWrite in that cycle.
- Flags written by instruction k are visible to the condition check of instruction k+1 in its DECODE cycle.
- Reset asserted mid-instruction aborts it: the next post-reset cycle is FETCH, with no pending writes.

## Structure
- Package mc_pkg:
  - statetype enum holding the encodings above.
  - Localparams for the ALUSrcB, ResultSrc and ALUControl codes.
- One sub-module, mc_cond_eval: Cond and Flags in, CondEx out, purely combinational.
- The Flags register reuses the existing flopenr (two instances, width 2).

## Test plan
- Reset, then a stream of ADD R1,R0,#5 (E2801005): state_o sequence 0,1,7,8,0. RegWrite=1 only in state 8. PCWrite=1 only in state 0.
- LDR R2,[R0,#8] (E5902008): states 0,1,2,3,4. AdrSrc=1 in state 3. ResultSrc=01 and RegWrite=1 in state 4.
- STR (E5802064): states 0,1,2,5. MemWrite=1 only in state 5; RegSrc=10.
- SUBS giving zero (ALUFlags=0100 during EXECUTER), then BEQ (0A000002): Flags Z=1, BEQ walks 0,1,9 with PCWrite=1 in state 9. Repeating with Z=0: BEQ takes 0,1 only, and PCWrite/RegWrite/MemWrite stay 0 after FETCH.
- ANDS (E2100000) with ALUFlags=1111: only N,Z are updated; C,V keep their prior value. Cond=1111 instruction: CondEx=0, 2 cycles.
- Assert reset during MEMWRITE: MemWrite drops immediately and state_o=0; after release the next edge moves to DECODE.
